// File: rtl/adder_pkg.sv
// Shared constants, the pipeline stage record and the segment-count helper
// for the pipelined ripple-carry adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;
  // Stage records are sized for the widest supported operand; the top uses the low WIDTH bits.
  localparam int MAX_WIDTH     = 64;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 carry;
  } stage_t;

  function automatic int num_segments(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry slice built from full adders.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             Cin,
  output logic [SLICE-1:0] S,
  output logic             Cout
);

  logic [SLICE:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[SLICE];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor, one SLICE-bit slice per stage.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output V.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int NSEG = num_segments(WIDTH, SLICE);

  if ((WIDTH % SLICE) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a multiple of SLICE and at most MAX_WIDTH");
  end

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // valid never waits on ready, and in_ready depends on out_ready only through
  // the advance chain, so a full pipe accepts and emits in the same cycle.
  stage_t           st_q   [NSEG];
  stage_t           src    [NSEG];
  stage_t           nxt    [NSEG];
  logic [SLICE-1:0] seg_a  [NSEG];
  logic [SLICE-1:0] seg_b  [NSEG];
  logic             seg_ci [NSEG];
  logic [SLICE-1:0] seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic [NSEG-1:0]  adv;

  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].a     = MAX_WIDTH'(A);
    src[0].b     = MAX_WIDTH'(sub ? ~B : B);
    src[0].carry = sub | cin;
    for (int k = 1; k < NSEG; k++) src[k] = st_q[k-1];
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_a[k]  = src[k].a[k*SLICE +: SLICE];
      seg_b[k]  = src[k].b[k*SLICE +: SLICE];
      seg_ci[k] = src[k].carry;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    adder_slice #(.SLICE(SLICE)) u_slice (
      .A    (seg_a[k]),
      .B    (seg_b[k]),
      .Cin  (seg_ci[k]),
      .S    (seg_s[k]),
      .Cout (seg_co[k])
    );
  end

  // Bubbles load as all-zero records so S/cout read 0 whenever nothing is in flight.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      nxt[k] = '0;
      if (src[k].valid) begin
        nxt[k]                        = src[k];
        nxt[k].sum[k*SLICE +: SLICE]  = seg_s[k];
        nxt[k].carry                  = seg_co[k];
      end
    end
  end

  always_comb begin
    adv         = '0;
    adv[NSEG-1] = !st_q[NSEG-1].valid || out_ready;
    for (int k = NSEG - 2; k >= 0; k--) adv[k] = !st_q[k].valid || adv[k+1];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NSEG; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (adv[k]) st_q[k] <= nxt[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = st_q[NSEG-1].valid;
  assign S         = st_q[NSEG-1].sum[WIDTH-1:0];
  assign cout      = st_q[NSEG-1].carry;

`ifdef PIPE_ADDER_OVF_EN
  logic v_q;
  logic msb_carry_in;

  // The full-adder sum bit reveals the carry that entered the MSB.
  assign msb_carry_in = seg_a[NSEG-1][SLICE-1] ^ seg_b[NSEG-1][SLICE-1] ^ seg_s[NSEG-1][SLICE-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v_q <= 1'b0;
    end else if (adv[NSEG-1]) begin
      v_q <= src[NSEG-1].valid & (msb_carry_in ^ seg_co[NSEG-1]);
    end
  end

  assign V = v_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder (default 16-bit, 4-bit slices).
// Also covers V when PIPE_ADDER_OVF_EN is defined.
module tb_pipelined_ripple_adder;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        cout;
`ifdef PIPE_ADDER_OVF_EN
  logic        V;
`endif

  int errors;
  int checks;
  int cyc;
  int tx_count;
  int first_tx;
  int last_tx;
  int acc_cyc;
  int dummy_cyc;

  // {V, cout, S}
  logic [17:0] exp_q[$];

  pipelined_ripple_adder dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .V         (V)
`endif
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // driver: present one operation and wait (bounded) for its acceptance
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                      input logic [15:0] es, input logic ec, input logic ev, output int acc);
    bit done;
    done     = 0;
    acc      = -1;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    cin      = c;
    sub      = s;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back({ev, ec, es});
        acc  = cyc;
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // scoreboard: every output transfer must match the head of exp_q
  always @(negedge Clk) begin
    logic [17:0] e;
    if (Reset_n && out_valid && out_ready) begin
      tx_count++;
      if (tx_count == 1) first_tx = cyc;
      last_tx = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
`ifdef PIPE_ADDER_OVF_EN
        check("result_v_cout_s", {14'd0, V, cout, S}, {14'd0, e});
`else
        check("result_cout_s", {15'd0, cout, S}, {15'd0, e[16:0]});
`endif
      end
    end
  end

  initial begin
    errors    = 0;
    checks    = 0;
    tx_count  = 0;
    first_tx  = 0;
    last_tx   = 0;
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 16'h0;
    B         = 16'h0;
    cin       = 1'b0;
    sub       = 1'b0;

    // reset state
    tick();
    tick();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_s", S, 16'h0000);
    check("reset_cout", cout, 1'b0);
    Reset_n = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1'b1);

    // add with carry-out, latency 4
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, dummy_cyc);
    check("lat_c1_out_valid", out_valid, 1'b0);
    tick();
    check("lat_c2_out_valid", out_valid, 1'b0);
    tick();
    check("lat_c3_out_valid", out_valid, 1'b0);
    tick();
    check("lat_c4_out_valid", out_valid, 1'b1);
    check("add_carry_s", S, 16'h0000);
    check("add_carry_cout", cout, 1'b1);
    drain();

    // subtract (cin ignored), add with cin, wraparound cases
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, dummy_cyc);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, dummy_cyc);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, dummy_cyc);
    send(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, dummy_cyc);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, dummy_cyc);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, dummy_cyc);
    drain();

    // streaming: 8 back-to-back ops, A=i, B=0x1000*i
    tx_count = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'(16'h1000 * i), 1'b0, 1'b0, 16'(16'h1001 * i), 1'b0, 1'b0, acc_cyc);
      if (i == 0) first_tx = -1000;
      if (i == 0) dummy_cyc = acc_cyc;
    end
    drain();
    check("stream_count", tx_count, 32'd8);
    check("stream_first_latency", first_tx - dummy_cyc, 32'd4);
    check("stream_consecutive", last_tx - first_tx, 32'd7);

    // backpressure: fill the pipe with out_ready low
    tx_count  = 0;
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, dummy_cyc);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, dummy_cyc);
    send(16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, dummy_cyc);
    send(16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, dummy_cyc);
    in_valid = 1'b1;
    A        = 16'h0001;
    B        = 16'h0002;
    cin      = 1'b0;
    sub      = 1'b1;
    #1;
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    check("full_s", S, 16'h0300);
    for (int n = 0; n < 2; n++) begin
      tick();
      check("frozen_s", S, 16'h0300);
      check("frozen_cout", cout, 1'b0);
      check("frozen_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 16'hFFFF});
    tick();
    in_valid = 1'b0;
    drain();
    check("backpressure_count", tx_count, 32'd5);

    // reset mid-flight discards in-flight operations
    send(16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0, dummy_cyc);
    send(16'h0044, 16'h0055, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0, dummy_cyc);
    A       = 16'h5A5A;
    B       = 16'hA5A5;
    Reset_n = 1'b0;
    exp_q.delete();
    tick();
    Reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      check("post_reset_out_valid", out_valid, 1'b0);
      tick();
    end
    check("post_reset_s", S, 16'h0000);
    check("post_reset_cout", cout, 1'b0);

`ifdef PIPE_ADDER_OVF_EN
    // signed overflow
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, dummy_cyc);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, dummy_cyc);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, dummy_cyc);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
